call_push_unit: RTL and testbench
=================================

Name: call_push_unit

Overview:
- Executes the CALL control-flow instruction, the push-side counterpart of the RET pop.
- Computes the return address from the current PC and writes it to the 256-entry x 19-bit call stack at the current stack pointer.
- Then issues a decremented stack pointer and a PC redirect to the call target.
- Sits between the instruction decoder and the PC/SP registers.
- Stack convention: grows downward, sp addresses the next free slot, empty stack is sp=255, and RET reads stack[sp+1].

Parameters:
- PC_W, 19, width of PC, target and stack entries
- SP_W, 8, width of stack pointer (stack depth 2^SP_W)
- RET_OFFSET, 1, value added to pc to form the return address
- SP_FLOOR, 0, lowest legal sp at which a push is refused (overflow)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- call_valid  in  1  decoder requests a CALL
- call_ready  out  1  unit idle; request accepted when valid&ready
- pc  in  PC_W  address of the CALL instruction (sampled on accept)
- target  in  PC_W  call destination (sampled on accept)
- sp  in  SP_W  current stack pointer (sampled on accept)
- stack_we  out  1  stack write strobe
- stack_addr  out  SP_W  stack write address
- stack_wdata  out  PC_W  return address to store
- pc_we  out  1  load new_pc into PC
- new_pc  out  PC_W  redirected PC
- sp_we  out  1  load new_sp into SP
- new_sp  out  SP_W  updated stack pointer
- done  out  1  one-cycle completion pulse
- overflow  out  1  one-cycle fault pulse, push refused

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE.
  - All registered outputs (stack_we, stack_addr, stack_wdata, pc_we, new_pc, sp_we, new_sp, done, overflow) = 0.
  - call_ready=1.
- call_ready = (state==IDLE), decoded from state, with no combinational path from call_valid.
- IDLE:
  - On call_valid&call_ready, latch pc, target and sp.
  - If sp==SP_FLOOR, go to FAULT; otherwise go to PUSH.
- PUSH (1 cycle):
  - stack_we=1, stack_addr=sp_latched, stack_wdata=(pc_latched+RET_OFFSET) mod 2^PC_W.
  - Next state: COMMIT.
- COMMIT (1 cycle):
  - pc_we=1, new_pc=target_latched.
  - sp_we=1, new_sp=sp_latched-1.
  - done=1.
  - Next state: IDLE.
- FAULT (1 cycle):
  - overflow=1, done=1.
  - stack_we=pc_we=sp_we=0; new_pc and new_sp hold their previous values.
  - Next state: IDLE.
- Strobes (stack_we, pc_we, sp_we, done, overflow) are high for exactly one cycle per accepted call.
- new_pc and new_sp hold their last values between calls.
- Latency:
  - Accept edge -> stack_we visible in the next cycle -> pc_we/sp_we/done one cycle after that.
  - A CALL occupies 3 cycles including the accept cycle.
  - Back-to-back: with call_valid held high, the next accept occurs in the cycle after done.
- Inputs change while busy: ignored. Only the values latched at accept are used.
- The stack write always precedes the SP update, so a RET that reads stack[new_sp+1] in the cycle after done sees the pushed entry.
- Arithmetic:
  - Return address wraps modulo 2^PC_W (pc=all-ones -> 0).
  - new_sp never wraps, because sp==SP_FLOOR is refused.
- sp=255 (empty stack) is a normal push.
- Reset mid-operation:
  - In PUSH: the write is aborted if reset arrives before the edge. No pc_we or sp_we follows.
  - In COMMIT: no further strobes are issued.
  - An already-completed stack write is not undone.

Test Plan:
- Reset -> call_ready=1; all strobes 0; new_pc=0, new_sp=0.
- Basic call: sp=254, pc=100, target=52, one-cycle call_valid.
  - Next cycle: stack_we=1, stack_addr=254, stack_wdata=101.
  - Following cycle: pc_we=sp_we=done=1, new_pc=52, new_sp=253.
  - Then call_ready=1.
- PC wrap: pc=19'h7FFFF, sp=255 -> stack_wdata=0, stack_addr=255, new_sp=254.
- Overflow: sp=0 -> one cycle later overflow=1 and done=1; stack_we, pc_we and sp_we stay 0 throughout; call_ready returns 1 the following cycle.
- Back-to-back: call_valid held, two calls with sp=200 then sp=199.
  - Writes to 200 and 199 exactly 3 cycles apart.
  - Input changes during the busy cycles do not alter the written values.
- Reset mid-op: assert rst during PUSH -> stack_we drops immediately; no pc_we, sp_we or done is ever seen; the next call after reset completes normally.

Source files
------------

// File: rtl/call_push_unit.sv
// CALL executor: pushes the return address onto the downward-growing call stack,
// then redirects the PC to the target and decrements SP; refuses pushes at the floor.
module call_push_unit #(
  parameter int PC_W       = 19,
  parameter int SP_W       = 8,
  parameter int RET_OFFSET = 1,
  parameter int SP_FLOOR   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            call_valid,
  output logic            call_ready,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] target,
  input  logic [SP_W-1:0] sp,
  output logic            stack_we,
  output logic [SP_W-1:0] stack_addr,
  output logic [PC_W-1:0] stack_wdata,
  output logic            pc_we,
  output logic [PC_W-1:0] new_pc,
  output logic            sp_we,
  output logic [SP_W-1:0] new_sp,
  output logic            done,
  output logic            overflow,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PUSH   = 2'd1,
    COMMIT = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] target_q, target_d;
  logic [SP_W-1:0] sp_lat_q, sp_lat_d;
  logic            stack_we_q, stack_we_d;
  logic [SP_W-1:0] stack_addr_q, stack_addr_d;
  logic [PC_W-1:0] stack_wdata_q, stack_wdata_d;
  logic            pc_we_q, pc_we_d;
  logic [PC_W-1:0] new_pc_q, new_pc_d;
  logic            sp_we_q, sp_we_d;
  logic [SP_W-1:0] new_sp_q, new_sp_d;
  logic            done_q, done_d;
  logic            overflow_q, overflow_d;

  // Handshake: a request transfers on a rising edge where call_valid && call_ready;
  // call_ready depends only on state, and pc/target/sp are sampled on that edge only.
  assign call_ready = (state_q == IDLE);

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    sp_lat_d      = sp_lat_q;
    stack_we_d    = 1'b0;
    stack_addr_d  = stack_addr_q;
    stack_wdata_d = stack_wdata_q;
    pc_we_d       = 1'b0;
    new_pc_d      = new_pc_q;
    sp_we_d       = 1'b0;
    new_sp_d      = new_sp_q;
    done_d        = 1'b0;
    overflow_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (call_valid) begin
          target_d = target;
          sp_lat_d = sp;
          if (sp == SP_W'(SP_FLOOR)) begin
            state_d    = FAULT;
            overflow_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            // Outputs are registered, so the write strobe appears in the PUSH cycle.
            state_d       = PUSH;
            stack_we_d    = 1'b1;
            stack_addr_d  = sp;
            stack_wdata_d = pc + PC_W'(RET_OFFSET);
          end
        end
      end
      PUSH: begin
        state_d  = COMMIT;
        pc_we_d  = 1'b1;
        new_pc_d = target_q;
        sp_we_d  = 1'b1;
        new_sp_d = sp_lat_q - SP_W'(1);
        done_d   = 1'b1;
      end
      COMMIT:  state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      target_q      <= '0;
      sp_lat_q      <= '0;
      stack_we_q    <= 1'b0;
      stack_addr_q  <= '0;
      stack_wdata_q <= '0;
      pc_we_q       <= 1'b0;
      new_pc_q      <= '0;
      sp_we_q       <= 1'b0;
      new_sp_q      <= '0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      sp_lat_q      <= sp_lat_d;
      stack_we_q    <= stack_we_d;
      stack_addr_q  <= stack_addr_d;
      stack_wdata_q <= stack_wdata_d;
      pc_we_q       <= pc_we_d;
      new_pc_q      <= new_pc_d;
      sp_we_q       <= sp_we_d;
      new_sp_q      <= new_sp_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
    end
  end

  assign stack_we    = stack_we_q;
  assign stack_addr  = stack_addr_q;
  assign stack_wdata = stack_wdata_q;
  assign pc_we       = pc_we_q;
  assign new_pc      = new_pc_q;
  assign sp_we       = sp_we_q;
  assign new_sp      = new_sp_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_call_push_unit.sv
// Bench for call_push_unit: a cycle-indexed schedule of expected outputs filled at
// each accepted call, compared every cycle, plus directed literal checks.
module tb_call_push_unit;

  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        call_valid = 1'b0;
  logic        call_ready;
  logic [18:0] pc = '0;
  logic [18:0] target = '0;
  logic [7:0]  sp = '0;
  logic        stack_we;
  logic [7:0]  stack_addr;
  logic [18:0] stack_wdata;
  logic        pc_we;
  logic [18:0] new_pc;
  logic        sp_we;
  logic [7:0]  new_sp;
  logic        done;
  logic        overflow;
  logic [1:0]  state_dbg;

  call_push_unit dut (
    .clk(clk), .rst(rst), .call_valid(call_valid), .call_ready(call_ready),
    .pc(pc), .target(target), .sp(sp),
    .stack_we(stack_we), .stack_addr(stack_addr), .stack_wdata(stack_wdata),
    .pc_we(pc_we), .new_pc(new_pc), .sp_we(sp_we), .new_sp(new_sp),
    .done(done), .overflow(overflow), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected outputs per cycle index; cyc counts rising edges.
  bit        e_swe [MAXC];
  bit [7:0]  e_addr[MAXC];
  bit [18:0] e_wdat[MAXC];
  bit        e_pwe [MAXC];
  bit        e_swe2[MAXC];
  bit        e_done[MAXC];
  bit        e_ovf [MAXC];
  bit [18:0] e_npc [MAXC];
  bit [7:0]  e_nsp [MAXC];
  int        cyc  = 0;
  int        free = 0;
  bit [18:0] m_new_pc = '0;
  bit [7:0]  m_new_sp = '0;
  bit        chk_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!rst && call_valid && (cyc - 1 >= free) && cyc + 2 < MAXC) begin
      if (sp == 8'd0) begin
        e_ovf[cyc]  = 1'b1;
        e_done[cyc] = 1'b1;
        free = cyc + 1;
      end else begin
        e_swe[cyc]    = 1'b1;
        e_addr[cyc]   = sp;
        e_wdat[cyc]   = 19'((20'(pc) + 20'd1) % 20'h80000);
        e_pwe[cyc+1]  = 1'b1;
        e_swe2[cyc+1] = 1'b1;
        e_done[cyc+1] = 1'b1;
        e_npc[cyc+1]  = target;
        e_nsp[cyc+1]  = 8'(int'(sp) - 1);
        free = cyc + 2;
      end
    end
    if (e_pwe[cyc]) m_new_pc = e_npc[cyc];
    if (e_swe2[cyc]) m_new_sp = e_nsp[cyc];
  end

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      chk("ready", 32'(call_ready), 32'(cyc >= free));
      chk("stack_we", 32'(stack_we), 32'(e_swe[cyc]));
      if (e_swe[cyc]) begin
        chk("stack_addr", 32'(stack_addr), 32'(e_addr[cyc]));
        chk("stack_wdata", 32'(stack_wdata), 32'(e_wdat[cyc]));
      end
      chk("pc_we", 32'(pc_we), 32'(e_pwe[cyc]));
      chk("sp_we", 32'(sp_we), 32'(e_swe2[cyc]));
      chk("done", 32'(done), 32'(e_done[cyc]));
      chk("overflow", 32'(overflow), 32'(e_ovf[cyc]));
      chk("new_pc", 32'(new_pc), 32'(m_new_pc));
      chk("new_sp", 32'(new_sp), 32'(m_new_sp));
    end
  end

  task automatic model_reset();
    for (int i = cyc; i < MAXC; i++) begin
      e_swe[i] = 0; e_pwe[i] = 0; e_swe2[i] = 0; e_done[i] = 0; e_ovf[i] = 0;
    end
    free = cyc;
    m_new_pc = '0;
    m_new_sp = '0;
  endtask

  task automatic idle_wait();
    int n = 0;
    while (cyc < free) begin
      @(posedge clk); #1;
      n++;
      if (n > 20) begin
        chk("idle_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  task automatic start_call(input logic [18:0] p, input logic [18:0] t, input logic [7:0] s);
    idle_wait();
    call_valid = 1'b1; pc = p; target = t; sp = s;
    @(posedge clk); #1;
    call_valid = 1'b0;
  endtask

  initial begin
    int w1, w2, r;
    chk_en = 1'b1;
    #2;
    chk("rst_ready", 32'(call_ready), 32'd1);
    chk("rst_strobes", 32'({stack_we, pc_we, sp_we, done, overflow}), 32'd0);
    chk("rst_new_pc", 32'(new_pc), 32'd0);
    chk("rst_new_sp", 32'(new_sp), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic call
    start_call(19'd100, 19'd52, 8'd254);
    @(negedge clk);
    chk("basic_we", 32'(stack_we), 32'd1);
    chk("basic_addr", 32'(stack_addr), 32'd254);
    chk("basic_wdata", 32'(stack_wdata), 32'd101);
    @(negedge clk);
    chk("basic_commit", 32'({pc_we, sp_we, done}), 32'h7);
    chk("basic_new_pc", 32'(new_pc), 32'd52);
    chk("basic_new_sp", 32'(new_sp), 32'd253);
    @(negedge clk);
    chk("basic_ready", 32'(call_ready), 32'd1);

    // PC wrap on the empty stack
    start_call(19'h7FFFF, 19'd3, 8'd255);
    @(negedge clk);
    chk("wrap_addr", 32'(stack_addr), 32'd255);
    chk("wrap_wdata", 32'(stack_wdata), 32'd0);
    @(negedge clk);
    chk("wrap_new_sp", 32'(new_sp), 32'd254);

    // Overflow refusal
    @(posedge clk); #1;
    start_call(19'd5, 19'd9, 8'd0);
    @(negedge clk);
    chk("ovf_flags", 32'({overflow, done}), 32'h3);
    chk("ovf_no_we", 32'({stack_we, pc_we, sp_we}), 32'd0);
    chk("ovf_hold_pc", 32'(new_pc), 32'd3);
    chk("ovf_hold_sp", 32'(new_sp), 32'd254);
    @(negedge clk);
    chk("ovf_ready", 32'(call_ready), 32'd1);
    chk("ovf_after", 32'({stack_we, pc_we, sp_we, overflow}), 32'd0);

    // Back-to-back with inputs churning while busy
    idle_wait();
    call_valid = 1'b1; pc = 19'd10; target = 19'd11; sp = 8'd200;
    @(posedge clk); #1;
    pc = 19'd999; target = 19'd888; sp = 8'd77;
    @(negedge clk);
    w1 = cyc;
    chk("b2b_addr1", 32'(stack_addr), 32'd200);
    chk("b2b_wdata1", 32'(stack_wdata), 32'd11);
    @(posedge clk); #1;
    pc = 19'd20; target = 19'd21; sp = 8'd199;
    @(negedge clk);
    chk("b2b_new_pc1", 32'(new_pc), 32'd11);
    chk("b2b_new_sp1", 32'(new_sp), 32'd199);
    @(posedge clk); #1;
    @(posedge clk); #1;
    call_valid = 1'b0;
    @(negedge clk);
    w2 = cyc;
    chk("b2b_we2", 32'(stack_we), 32'd1);
    chk("b2b_addr2", 32'(stack_addr), 32'd199);
    chk("b2b_wdata2", 32'(stack_wdata), 32'd21);
    chk("b2b_gap", 32'(w2 - w1), 32'd3);

    // Reset during PUSH
    start_call(19'd1, 19'd2, 8'd100);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_we", 32'(stack_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    start_call(19'd7, 19'd8, 8'd50);
    @(negedge clk);
    chk("post_rst_wdata", 32'(stack_wdata), 32'd8);
    @(negedge clk);
    chk("post_rst_new_pc", 32'(new_pc), 32'd8);
    chk("post_rst_new_sp", 32'(new_sp), 32'd49);

    // Random traffic, valid toggled regardless of ready
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      call_valid = ($urandom_range(0, 9) < 7);
      pc = 19'($urandom);
      target = 19'($urandom);
      r = $urandom_range(0, 9);
      sp = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 255));
    end
    @(posedge clk); #1;
    call_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
